fp_result_buffer: RTL

Downstream stage of the single-precision floating-point multiplier. Accepts the multiplier's registered 32-bit result stream with a companion valid strobe, classifies each result, and holds it in a small FIFO. Results leave through a valid/ready port, and the block keeps saturating exception counters for monitoring. The multiplier cannot stall, so the buffer never back-pressures it: a write into a full buffer is dropped and counted.

---
 rtl/fp_result_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fp_result_buffer.sv
// Result FIFO behind the FP multiplier: classifies each result on entry, never back-pressures
// the multiplier (writes into a full buffer are dropped), and keeps saturating event counters.
module fp_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [31:0]                i_res,
  input  logic                       i_clr_cnt,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [31:0]                o_data,
  output logic [2:0]                 o_class,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_W-1:0]           o_nan_cnt,
  output logic [CNT_W-1:0]           o_inf_cnt,
  output logic [CNT_W-1:0]           o_zero_cnt,
  output logic [CNT_W-1:0]           o_sub_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] ClsZero = 3'b000;
  localparam logic [2:0] ClsSub  = 3'b001;
  localparam logic [2:0] ClsNorm = 3'b011;
  localparam logic [2:0] ClsInf  = 3'b100;
  localparam logic [2:0] ClsNan  = 3'b110;

  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [2:0]       class_q [DEPTH];
  logic [2:0]       class_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, sub_q, sub_d, drop_q, drop_d;

  logic       full, pop, push, drop;
  logic [2:0] in_class;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    in_class = ClsNorm;
    if (i_res[30:23] == 8'h00) begin
      in_class = (i_res[22:0] == 23'd0) ? ClsZero : ClsSub;
    end else if (i_res[30:23] == 8'hff) begin
      in_class = (i_res[22:0] == 23'd0) ? ClsInf : ClsNan;
    end
  end

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign full = (count_q == CW'(DEPTH));
  assign pop  = o_valid & i_ready;
  assign push = i_valid & (~full | pop);
  assign drop = i_valid & full & ~pop;

  always_comb begin
    data_d   = data_q;
    class_d  = class_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q]  = i_res;
      class_d[wr_ptr_q] = in_class;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    nan_d  = nan_q;
    inf_d  = inf_q;
    zero_d = zero_q;
    sub_d  = sub_q;
    drop_d = drop_q;
    if (i_clr_cnt) begin
      nan_d  = '0;
      inf_d  = '0;
      zero_d = '0;
      sub_d  = '0;
      drop_d = '0;
    end else begin
      if (drop) drop_d = sat_inc(drop_q);
      if (push) begin
        unique case (in_class)
          ClsNan:  nan_d  = sat_inc(nan_q);
          ClsInf:  inf_d  = sat_inc(inf_q);
          ClsZero: zero_d = sat_inc(zero_q);
          ClsSub:  sub_d  = sat_inc(sub_q);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i]  <= '0;
        class_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nan_q    <= '0;
      inf_q    <= '0;
      zero_q   <= '0;
      sub_q    <= '0;
      drop_q   <= '0;
    end else begin
      data_q   <= data_d;
      class_q  <= class_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      sub_q    <= sub_d;
      drop_q   <= drop_d;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_empty    = (count_q == '0);
  assign o_full     = full;
  assign o_ready    = (count_q < CW'(DEPTH));
  assign o_count    = count_q;
  assign o_data     = data_q[rd_ptr_q];
  assign o_class    = class_q[rd_ptr_q];
  assign o_nan_cnt  = nan_q;
  assign o_inf_cnt  = inf_q;
  assign o_zero_cnt = zero_q;
  assign o_sub_cnt  = sub_q;
  assign o_drop_cnt = drop_q;

endmodule
